fpnew_divsqrt_iter: RTL and testbench



---
 rtl/fpnew_pkg.sv | 22 ++
 rtl/fpnew_divsqrt_result_fifo.sv | 63 ++++++
 rtl/fpnew_divsqrt_iter.sv | 209 ++++++++++++++++++++
 tb/tb_fpnew_divsqrt_iter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpnew_pkg.sv
// Shared types for the FPnew iterative divide / square-root engine.
// Holds the operation encoding, FSM states and the per-operation cycle-count helper.
package fpnew_pkg;

    typedef enum logic {
        ITER_DIV  = 1'b0,
        ITER_SQRT = 1'b1
    } iter_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } iter_state_e;

    // Division retires `width` result bits; square root retires width/2.
    function automatic int iter_cycles(input int width, input int bpc, input iter_op_e op);
        int bits;
        bits = (op == ITER_SQRT) ? width / 2 : width;
        return (bits + bpc - 1) / bpc;
    endfunction

endpackage

// File: rtl/fpnew_divsqrt_result_fifo.sv
// In-order result buffer for the divide / square-root engine.
// Generic over the entry type; flush empties it on the next edge.
module fpnew_divsqrt_result_fifo #(
    parameter type entry_t = logic,
    parameter int  Depth   = 2,
    localparam int PtrW    = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int CntW    = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            push_i,
    input  entry_t          data_i,
    input  logic            pop_i,
    output entry_t          data_o,
    output logic            valid_o,
    output logic [CntW-1:0] count_o
);

    entry_t            mem [Depth];
    logic [PtrW-1:0]   rd_ptr_q;
    logic [PtrW-1:0]   wr_ptr_q;
    logic [CntW-1:0]   count_q;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push_i && !flush_i && (count_q != CntW'(Depth));
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset: valid_o gates it.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/fpnew_divsqrt_iter.sv
// Iterative unsigned divide / integer square root, BitsPerCycle bits per clock.
// Define FPNEW_DIVSQRT_EARLY_EXIT_EN to finish zero-operand and divide-by-zero cases in one cycle.
module fpnew_divsqrt_iter
    import fpnew_pkg::*;
#(
    parameter int  Width        = 24,
    parameter int  BitsPerCycle = 1,
    parameter int  ResultDepth  = 2,
    parameter type TagType      = logic
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  iter_op_e         op_i,
    input  logic [Width-1:0] operand_a_i,
    input  logic [Width-1:0] operand_b_i,
    input  TagType           tag_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] result_o,
    output logic [Width-1:0] remainder_o,
    output logic             inexact_o,
    output logic             div_by_zero_o,
    output TagType           tag_o,
    output logic             busy_o
);

    localparam int RemW      = Width + 2;
    localparam int CntW      = $clog2(Width + 1);
    localparam int FifoCntW  = $clog2(ResultDepth + 1);
    localparam int NiterDiv  = iter_cycles(Width, BitsPerCycle, ITER_DIV);
    localparam int NiterSqrt = iter_cycles(Width, BitsPerCycle, ITER_SQRT);
    localparam int LastDiv   = Width - (NiterDiv - 1) * BitsPerCycle;
    localparam int LastSqrt  = Width / 2 - (NiterSqrt - 1) * BitsPerCycle;

    typedef struct packed {
        logic [Width-1:0] result;
        logic [Width-1:0] remainder;
        logic             inexact;
        logic             div_by_zero;
        TagType           tag;
    } entry_t;

    // Both ports use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
    iter_state_e         state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [Width-1:0]    a_q, a_d;
    logic [RemW-1:0]     rem_q, rem_d;
    logic [Width-1:0]    res_q, res_d;
    logic [Width-1:0]    b_q;
    iter_op_e            op_q;
    TagType              tag_q;
    logic                early_q, early_d;

    logic [Width-1:0]    s_a;
    logic [RemW-1:0]     s_rem;
    logic [Width-1:0]    s_res;
    logic [RemW-1:0]     sh;
    logic [RemW-1:0]     trial;
    int                  n_steps;

    logic                accept;
    logic                push;
    logic                is_dz;
    entry_t              push_entry;
    entry_t              head;
    logic                fifo_valid;
    logic [FifoCntW-1:0] fifo_count;

    assign in_ready_o = (state_q == IDLE) && (fifo_count < FifoCntW'(ResultDepth)) && !flush_i;
    assign accept     = in_valid_i && in_ready_o;

`ifdef FPNEW_DIVSQRT_EARLY_EXIT_EN
    assign early_d = ((op_i == ITER_DIV) && ((operand_b_i == '0) || (operand_a_i == '0)))
                  || ((op_i == ITER_SQRT) && (operand_a_i == '0));
`else
    assign early_d = 1'b0;
`endif

    // Restoring steps for this cycle; the final cycle only runs the leftover steps.
    always_comb begin
        s_a     = a_q;
        s_rem   = rem_q;
        s_res   = res_q;
        sh      = '0;
        trial   = '0;
        n_steps = (cnt_q == CntW'(1)) ? ((op_q == ITER_DIV) ? LastDiv : LastSqrt) : BitsPerCycle;
        for (int i = 0; i < BitsPerCycle; i++) begin
            if (i < n_steps) begin
                if (op_q == ITER_DIV) begin
                    sh    = {s_rem[RemW-2:0], s_a[Width-1]};
                    trial = {2'b00, b_q};
                    s_a   = s_a << 1;
                end else begin
                    sh    = {s_rem[RemW-3:0], s_a[Width-1 -: 2]};
                    trial = {s_res, 2'b01};
                    s_a   = s_a << 2;
                end
                if (sh >= trial) begin
                    s_rem = sh - trial;
                    s_res = {s_res[Width-2:0], 1'b1};
                end else begin
                    s_rem = sh;
                    s_res = {s_res[Width-2:0], 1'b0};
                end
            end
        end
    end

    // Early-exit cases all leave the remainder equal to the untouched operand a.
    always_comb begin
        is_dz                  = (op_q == ITER_DIV) && (b_q == '0);
        push_entry             = '0;
        push_entry.result      = early_q ? (is_dz ? '1 : '0) : s_res;
        push_entry.remainder   = early_q ? a_q : s_rem[Width-1:0];
        push_entry.inexact     = !is_dz && (push_entry.remainder != '0);
        push_entry.div_by_zero = is_dz;
        push_entry.tag         = tag_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        rem_d   = rem_q;
        res_d   = res_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    cnt_d   = (op_i == ITER_DIV) ? CntW'(NiterDiv) : CntW'(NiterSqrt);
                    a_d     = operand_a_i;
                    rem_d   = '0;
                    res_d   = '0;
                end
            end
            RUN: begin
                a_d   = s_a;
                rem_d = s_rem;
                res_d = s_res;
                cnt_d = cnt_q - 1'b1;
                if ((cnt_q == CntW'(1)) || early_q) begin
                    push    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            push    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            rem_q   <= '0;
            res_q   <= '0;
            b_q     <= '0;
            op_q    <= ITER_DIV;
            tag_q   <= '0;
            early_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
            if (accept) begin
                b_q     <= operand_b_i;
                op_q    <= op_i;
                tag_q   <= tag_i;
                early_q <= early_d;
            end
        end
    end

    fpnew_divsqrt_result_fifo #(
        .entry_t (entry_t),
        .Depth   (ResultDepth)
    ) i_result_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (out_ready_i && out_valid_o),
        .data_o  (head),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign out_valid_o   = fifo_valid && !flush_i;
    assign result_o      = head.result;
    assign remainder_o   = head.remainder;
    assign inexact_o     = head.inexact;
    assign div_by_zero_o = head.div_by_zero;
    assign tag_o         = head.tag;
    assign busy_o        = (state_q == RUN) || (fifo_count != '0);

endmodule

// File: tb/tb_fpnew_divsqrt_iter.sv
// Directed bench for fpnew_divsqrt_iter: Width=8, ResultDepth=2, with BitsPerCycle=1 and 3 instances.
// Expected results are hand-computed; outputs are sampled on the falling edge.
module tb_fpnew_divsqrt_iter;
    import fpnew_pkg::*;

    localparam int W  = 8;
    localparam int EW = 4 + 1 + 1 + W + W;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT, BitsPerCycle = 1 ----------------
    logic         in_valid, in_ready, flush, out_valid, out_ready;
    logic         inexact, dz, busy;
    iter_op_e     op;
    logic [W-1:0] a, b, result, remainder;
    logic [3:0]   tag, tag_out;

    fpnew_divsqrt_iter #(
        .Width(W), .BitsPerCycle(1), .ResultDepth(2), .TagType(logic [3:0])
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_i(op), .operand_a_i(a), .operand_b_i(b), .tag_i(tag), .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
        .remainder_o(remainder), .inexact_o(inexact), .div_by_zero_o(dz),
        .tag_o(tag_out), .busy_o(busy)
    );

    // ---------------- DUT, BitsPerCycle = 3 ----------------
    logic         in_valid3, in_ready3, out_valid3, out_ready3;
    logic         inexact3, dz3, busy3;
    iter_op_e     op3;
    logic [W-1:0] a3, b3, result3, remainder3;
    logic [3:0]   tag_out3;

    fpnew_divsqrt_iter #(
        .Width(W), .BitsPerCycle(3), .ResultDepth(2), .TagType(logic [3:0])
    ) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid3), .in_ready_o(in_ready3),
        .op_i(op3), .operand_a_i(a3), .operand_b_i(b3), .tag_i(4'd0), .flush_i(1'b0),
        .out_valid_o(out_valid3), .out_ready_i(out_ready3), .result_o(result3),
        .remainder_o(remainder3), .inexact_o(inexact3), .div_by_zero_o(dz3),
        .tag_o(tag_out3), .busy_o(busy3)
    );

    // ---------------- scoreboard ----------------
    int             n_checks = 0;
    int             n_fail   = 0;
    logic [EW-1:0]  exp_q[$];
    int             acc_cyc  = 0;
    int             lat;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack(input logic [3:0] t, input logic d, input logic inx,
                                           input logic [W-1:0] rem, input logic [W-1:0] res);
        return {t, d, inx, rem, res};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input iter_op_e o, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [3:0] t);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        a        = va;
        b        = vb;
        tag      = t;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic wait_valid(output int l);
        int guard = 0;
        l = -1;
        @(negedge clk);
        while (!out_valid && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (out_valid) l = cyc - acc_cyc;
        else check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic collect(output int l);
        logic [EW-1:0] e;
        wait_valid(l);
        if (!out_valid) return;
        if (exp_q.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("tag", 32'(tag_out), 32'(e[EW-1 -: 4]));
            check("div_by_zero", 32'(dz), 32'(e[2*W+1]));
            check("inexact", 32'(inexact), 32'(e[2*W]));
            check("remainder", 32'(remainder), 32'(e[2*W-1:W]));
            check("result", 32'(result), 32'(e[W-1:0]));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run3(input iter_op_e o, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] eres, input logic [W-1:0] erem,
                        input logic einx, input int elat);
        int guard = 0;
        int acc3;
        @(negedge clk);
        check("bpc3_in_ready", 32'(in_ready3), 32'd1);
        in_valid3 = 1'b1;
        op3       = o;
        a3        = va;
        b3        = vb;
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        acc3      = cyc;
        @(negedge clk);
        while (!out_valid3 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("bpc3_latency", 32'(cyc - acc3), 32'(elat));
        check("bpc3_result", 32'(result3), 32'(eres));
        check("bpc3_remainder", 32'(remainder3), 32'(erem));
        check("bpc3_inexact", 32'(inexact3), 32'(einx));
        out_ready3 = 1'b1;
        @(posedge clk);
        #1;
        out_ready3 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        in_valid = 0; op = ITER_DIV; a = '0; b = '0; tag = '0; flush = 0; out_ready = 0;
        in_valid3 = 0; op3 = ITER_DIV; a3 = '0; b3 = '0; out_ready3 = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_busy3", 32'(busy3), 32'd0);

        // Divide with remainder
        exp_q.push_back(pack(4'd1, 1'b0, 1'b1, 8'd4, 8'd28));
        send(ITER_DIV, 8'd200, 8'd7, 4'd1);
        collect(lat);
        check("latency_div", 32'(lat), 32'd8);

        // Square roots, inexact and exact
        repeat ($urandom_range(0, 2)) @(negedge clk);
        exp_q.push_back(pack(4'd2, 1'b0, 1'b1, 8'd4, 8'd14));
        send(ITER_SQRT, 8'd200, 8'd0, 4'd2);
        collect(lat);
        check("latency_sqrt", 32'(lat), 32'd4);
        exp_q.push_back(pack(4'd3, 1'b0, 1'b0, 8'd0, 8'd14));
        send(ITER_SQRT, 8'd196, 8'd99, 4'd3);
        collect(lat);

        // Divide by zero
        exp_q.push_back(pack(4'd4, 1'b1, 1'b0, 8'd5, 8'hFF));
        send(ITER_DIV, 8'd5, 8'd0, 4'd4);
        collect(lat);
`ifdef FPNEW_DIVSQRT_EARLY_EXIT_EN
        check("latency_div0", 32'(lat), 32'd1);
`else
        check("latency_div0", 32'(lat), 32'd8);
`endif

        // Back-pressure: two results fill the buffer, the third op must wait
        exp_q.push_back(pack(4'd1, 1'b0, 1'b1, 8'd1, 8'd33));
        exp_q.push_back(pack(4'd2, 1'b0, 1'b0, 8'd0, 8'd10));
        exp_q.push_back(pack(4'd3, 1'b0, 1'b1, 8'd1, 8'd4));
        send(ITER_DIV, 8'd100, 8'd3, 4'd1);
        send(ITER_DIV, 8'd50, 8'd5, 4'd2);
        @(negedge clk);
        in_valid = 1'b1; op = ITER_DIV; a = 8'd9; b = 8'd2; tag = 4'd3;
        repeat (12) @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_busy", 32'(busy), 32'd1);
        collect(lat);
        send(ITER_DIV, 8'd9, 8'd2, 4'd3);
        collect(lat);
        collect(lat);
        check("drained_queue", 32'(exp_q.size()), 32'd0);

        // Flush with one buffered result and one op in flight
        send(ITER_DIV, 8'd9, 8'd2, 4'd6);
        wait_valid(lat);
        check("flush_pre_valid", 32'(out_valid), 32'd1);
        send(ITER_DIV, 8'd200, 8'd7, 4'd5);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_masks_valid", 32'(out_valid), 32'd0);
        check("flush_blocks_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        repeat (12) @(negedge clk);
        check("flush_no_output", 32'(out_valid), 32'd0);
        exp_q.push_back(pack(4'd7, 1'b0, 1'b1, 8'd15, 8'd15));
        send(ITER_DIV, 8'd255, 8'd16, 4'd7);
        collect(lat);
        check("latency_after_flush", 32'(lat), 32'd8);

        // Three bits per cycle, including a short final cycle
        run3(ITER_DIV, 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 3);
        run3(ITER_SQRT, 8'd255, 8'd0, 8'd15, 8'd30, 1'b1, 2);

        repeat (2) @(negedge clk);
        check("final_busy", 32'(busy), 32'd0);
        check("final_busy3", 32'(busy3), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
